// File: rtl/glitch_cmd_master_pkg.sv
// rtl/glitch_cmd_master_pkg.sv - opcodes, FSM encoding and frame lookup for the glitcher command master
package glitch_cmd_master_pkg;

  localparam logic [7:0] CMD_POWER_CYCLE = 8'd66;  // 'B'
  localparam logic [7:0] CMD_SET_DELAY   = 8'd67;  // 'C'
  localparam logic [7:0] CMD_SET_WIDTH   = 8'd68;  // 'D'
  localparam logic [7:0] CMD_SET_COUNT   = 8'd69;  // 'E'
  localparam logic [7:0] CMD_ARM         = 8'd70;  // 'F'
  localparam logic [7:0] CMD_GET_STATUS  = 8'd71;  // 'G'
  localparam logic [7:0] CMD_SET_OFFSET  = 8'd72;  // 'H'
  localparam logic [7:0] CMD_GET_STATE   = 8'd73;  // 'I'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_HOLD,
    ST_WAIT_TX,
    ST_WAIT_RSP
  } state_t;

  typedef struct packed {
    logic [2:0] payload_len;
    logic       expects_rsp;
  } frame_info_t;

  function automatic frame_info_t opcode_info(input logic [7:0] op);
    frame_info_t fi;
    fi.payload_len = 3'd0;
    fi.expects_rsp = 1'b0;
    case (op)
      CMD_SET_DELAY, CMD_SET_WIDTH, CMD_SET_COUNT: fi.payload_len = 3'd4;
      CMD_SET_OFFSET:                              fi.payload_len = 3'd1;
      CMD_GET_STATUS, CMD_GET_STATE:               fi.expects_rsp = 1'b1;
      default: ;
    endcase
    return fi;
  endfunction

endpackage

// File: rtl/glitch_cmd_master_rsp_timer.sv
// rtl/glitch_cmd_master_rsp_timer.sv - response wait timer with clear, enable and terminal-count compare
module rsp_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else if (clear) begin
      count_q <= 32'd0;
    end else if (enable) begin
      count_q <= count_q + 32'd1;
    end
  end

  // First enabled cycle sees count 0, so expiry lands on the TIMEOUT_CYCLES-th one.
  assign expired = enable && (count_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/glitch_cmd_master.sv
// rtl/glitch_cmd_master.sv - UART command initiator; response timeout built only with GLITCH_CMD_TIMEOUT_EN
module glitch_cmd_master
  import glitch_cmd_master_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_enable,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] arg_q;
  frame_info_t info_q;
  logic [2:0]  idx_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_valid_q;
  logic        rsp_timeout_q;
  logic [7:0]  next_byte;
  logic        accept;
  logic        byte_sent;
  logic        timer_expired;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign byte_sent = (state_q == ST_SEND) && tx_ready;

  // idx_q counts bytes already handed to the transmitter; byte 0 is the opcode.
  always_comb begin
    next_byte = op_q;
    case (idx_q)
      3'd0:    next_byte = op_q;
      3'd1:    next_byte = (info_q.payload_len == 3'd4) ? arg_q[31:24] : arg_q[7:0];
      3'd2:    next_byte = arg_q[23:16];
      3'd3:    next_byte = arg_q[15:8];
      default: next_byte = arg_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SEND;
      ST_SEND:  if (tx_ready) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_ready) begin
          if (idx_q <= info_q.payload_len) begin
            state_d = ST_LOAD;
          end else if (info_q.expects_rsp) begin
            state_d = ST_WAIT_RSP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_RSP: if (rx_valid || timer_expired) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= 8'd0;
      arg_q         <= 32'd0;
      info_q        <= '0;
      idx_q         <= 3'd0;
      tx_data_q     <= 8'd0;
      rsp_data_q    <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      if (accept) begin
        op_q   <= cmd_opcode;
        arg_q  <= cmd_arg;
        info_q <= opcode_info(cmd_opcode);
        idx_q  <= 3'd0;
      end
      if (state_q == ST_LOAD) tx_data_q <= next_byte;
      if (byte_sent) idx_q <= idx_q + 3'd1;
      // A receiver strobe beats a simultaneous expiry.
      if (state_q == ST_WAIT_RSP) begin
        if (rx_valid) begin
          rsp_data_q  <= rx_data;
          rsp_valid_q <= 1'b1;
        end else if (timer_expired) begin
          rsp_timeout_q <= 1'b1;
        end
      end
    end
  end

`ifdef GLITCH_CMD_TIMEOUT_EN
  logic timer_clear;

  assign timer_clear = (state_q == ST_WAIT_TX) && (state_d == ST_WAIT_RSP);

  rsp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state_q == ST_WAIT_RSP),
    .expired(timer_expired)
  );
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timer_expired         = 1'b0;
`endif

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tx_data     = tx_data_q;
  assign tx_enable   = reset && byte_sent;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_glitch_cmd_master.sv
// tb/tb_glitch_cmd_master.sv - scoreboard bench for glitch_cmd_master with transmitter/receiver models
module tb_glitch_cmd_master;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_opcode = 8'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_timeout, busy, tx_enable;
  logic [7:0]  rsp_data, tx_data;

  glitch_cmd_master #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       is_to;
    logic [7:0] data;
  } rsp_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_bytes[$];
  rsp_t       exp_rsp[$];
  int         exp_first = -1;
  int         rsp_due = -1;
  int         tx_lat = 3;
  int         q_mode = 0;
  int         q_delay = 0;
  logic [7:0] q_byte = 8'd0;
  bit         q_armed = 1'b0;
  int         rx_at = -1;
  logic [7:0] rx_byte = 8'd0;
  int         sent_in_frame = 0;
  logic [7:0] last_rsp = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_query(input logic [7:0] op);
    return (op == 8'd71) || (op == 8'd73);
  endfunction

  // Reference framing: opcode, then the argument bytes the command carries, MSB first.
  function automatic void push_frame(input logic [7:0] op, input logic [31:0] arg);
    exp_bytes.push_back(op);
    if (op == 8'd67 || op == 8'd68 || op == 8'd69) begin
      for (int k = 3; k >= 0; k--) exp_bytes.push_back(arg[8*k +: 8]);
    end else if (op == 8'd72) begin
      exp_bytes.push_back(arg[7:0]);
    end
  endfunction

  // Transmitter: ready drops one cycle after the start pulse, stays low tx_lat cycles.
  // Receiver: strobes rx_byte in cycle rx_at.
  initial begin : tx_rx_model
    logic en;
    bit   pend;
    int   cnt;
    int   j;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      en = tx_enable;
      j  = cyc;
      if (en && q_armed) begin
        q_armed = 1'b0;
        case (q_mode)
          1: begin rx_at = j + q_delay; rx_byte = q_byte; rsp_due = rx_at + 1; end
          2: rsp_due = j + 3 + tx_lat + T;
          3: begin rx_at = j + 2 + tx_lat + T; rx_byte = q_byte; rsp_due = rx_at + 1; end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      if (pend) begin
        tx_ready = 1'b0;
        cnt      = tx_lat;
        pend     = 1'b0;
      end else if (!tx_ready) begin
        cnt--;
        if (cnt <= 0) tx_ready = 1'b1;
      end
      if (en) pend = 1'b1;
      rx_valid = (cyc == rx_at);
      rx_data  = rx_valid ? rx_byte : 8'($urandom);
    end
  end

  initial begin : monitor
    logic [7:0] eb;
    rsp_t       r;
    forever begin
      @(negedge clk);
      if (tx_enable) begin
        if (exp_bytes.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: actual byte 0x%0h required no tx_enable (cycle %0d)", tx_data, cyc);
        end else begin
          eb = exp_bytes.pop_front();
          check("tx_byte", {24'd0, tx_data}, {24'd0, eb});
        end
        if (exp_first >= 0) begin
          check("first_tx_latency", cyc, exp_first);
          exp_first = -1;
        end
        sent_in_frame++;
      end
      if (rsp_valid || rsp_timeout) begin
        check("rsp_exclusive", {31'd0, rsp_valid & rsp_timeout}, 32'd0);
        check("ready_with_rsp", {31'd0, cmd_ready}, 32'd1);
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: actual valid=%0d timeout=%0d required none (cycle %0d)", rsp_valid, rsp_timeout, cyc);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_kind_timeout", {31'd0, rsp_timeout}, {31'd0, r.is_to});
          if (!r.is_to) check("rsp_data", {24'd0, rsp_data}, {24'd0, r.data});
          check("rsp_cycle", cyc, rsp_due);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: actual cycle %0d required completion", cyc);
    $fatal(1, "bench stalled");
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] arg, input int mode,
                       input int delay, input logic [7:0] rbyte);
    int guard;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((!tx_ready || !cmd_ready) && guard < 1000);
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL issue_wait: actual ready=%0d tx_ready=%0d required 1/1", cmd_ready, tx_ready);
    end
    push_frame(op, arg);
    if (is_query(op)) begin
      q_mode  = mode;
      q_delay = delay;
      q_byte  = rbyte;
      q_armed = 1'b1;
      if (mode != 2) exp_rsp.push_back(rsp_t'({1'b0, rbyte}));
`ifdef GLITCH_CMD_TIMEOUT_EN
      else exp_rsp.push_back(rsp_t'({1'b1, 8'h00}));
`endif
    end
    sent_in_frame = 0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_arg    = arg;
    exp_first  = cyc + 2;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_opcode = 8'($urandom);
    cmd_arg    = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_bytes.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL idle_timeout: actual busy=%0d required 0 within %0d cycles", busy, budget);
    end
    @(posedge clk); #1;
    check("rsp_queue_drained", exp_rsp.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_bytes.delete();
    exp_rsp.delete();
    exp_first = -1;
    q_armed   = 1'b0;
    rx_at     = -1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    last_rsp = 8'd0;
  endtask

  initial begin : stimulus
    logic [7:0]  op;
    logic [31:0] arg;
    int          r, m, guard;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b1;

    tx_lat = 10;
    issue(8'h44, 32'h0000_1234, 0, 0, 8'h00);
    wait_idle(2000);
    check("ready_after_D", {31'd0, cmd_ready}, 32'd1);

    issue(8'h48, 32'hFFFF_FF01, 0, 0, 8'h00);
    wait_idle(2000);

    tx_lat = 3;
    issue(8'h47, $urandom, 1, 50, 8'hA5);
    wait_idle(2000);
    last_rsp = 8'hA5;
    check("rsp_data_held", {24'd0, rsp_data}, {24'd0, last_rsp});

`ifdef GLITCH_CMD_TIMEOUT_EN
    issue(8'h49, $urandom, 2, 0, 8'h00);
    wait_idle(2000);
    check("rsp_data_after_timeout", {24'd0, rsp_data}, {24'd0, last_rsp});
    issue(8'h47, $urandom, 3, 0, 8'h3C);
    wait_idle(2000);
    last_rsp = 8'h3C;
`else
    issue(8'h47, $urandom, 1, tx_lat + 3 + T + 50, 8'h3C);
    wait_idle(2000);
    last_rsp = 8'h3C;
    issue(8'h49, $urandom, 2, 0, 8'h00);
    repeat (300) @(posedge clk);
    #1;
    check("waits_without_timeout", {31'd0, busy}, 32'd1);
    do_reset();
`endif
    check("rsp_data_last", {24'd0, rsp_data}, {24'd0, last_rsp});

    issue(8'h43, $urandom, 0, 0, 8'h00);
    rx_byte = last_rsp ^ 8'h5A;
    rx_at   = cyc + 4;
    wait_idle(2000);
    check("stray_rx_ignored", {24'd0, rsp_data}, {24'd0, last_rsp});

    tx_lat = 8;
    issue(8'h45, 32'hDEAD_BEEF, 0, 0, 8'h00);
    guard = 0;
    while (sent_in_frame < 2 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reached_second_byte", {31'd0, sent_in_frame >= 2}, 32'd1);
    do_reset();
    repeat (40) @(posedge clk);
    tx_lat = 2;
    issue(8'h42, $urandom, 0, 0, 8'h00);
    wait_idle(2000);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 11);
      if (r < 10) op = 8'h41 + 8'(r);
      else if (r == 10) op = 8'h00;
      else op = 8'($urandom);
      arg    = $urandom;
      tx_lat = $urandom_range(1, 6);
`ifdef GLITCH_CMD_TIMEOUT_EN
      m = $urandom_range(1, 3);
`else
      m = 1;
`endif
      issue(op, arg, m, tx_lat + 3 + $urandom_range(0, 40), 8'($urandom));
      if (!is_query(op) && $urandom_range(0, 1) == 1) begin
        rx_byte = 8'($urandom);
        rx_at   = cyc + 2;
      end
      wait_idle(2000);
      if (is_query(op) && m != 2) last_rsp = q_byte;
      check("rand_rsp_data", {24'd0, rsp_data}, {24'd0, last_rsp});
    end

    check("bytes_drained", exp_bytes.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
